// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Brief    : Shared widths, op encodings and FSM states for the memory responder
// Revision : 1.0 - initial release
// ============================================================================
package mem_pkg;

    localparam int ADDR_W    = 5;
    localparam int DATA_W    = 3;
    localparam int MEM_WORDS = 32;

    localparam logic [1:0] OP_READ    = 2'b00;
    localparam logic [1:0] OP_WRITE   = 2'b01;
    localparam logic [1:0] OP_WB_READ = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/main_memory_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : main_memory_responder_if
// Brief    : Request/response channel and debug peek port between L1 and memory
// Revision : 1.0 - initial release
// ============================================================================
interface main_memory_responder_if
    import mem_pkg::*;
();

    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [ADDR_W-1:0] req_address;
    logic [DATA_W-1:0] req_wdata;
    logic [ADDR_W-1:0] wb_address;
    logic [DATA_W-1:0] wb_data;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_data;
    logic [ADDR_W-1:0] peek_address;
    logic [DATA_W-1:0] peek_data;

    modport master (
        output req_valid, req_op, req_address, req_wdata, wb_address, wb_data,
        output peek_address,
        input  req_ready, resp_valid, resp_data, peek_data
    );

    modport slave (
        input  req_valid, req_op, req_address, req_wdata, wb_address, wb_data,
        input  peek_address,
        output req_ready, resp_valid, resp_data, peek_data
    );

endinterface
`default_nettype wire

// File: rtl/mem_array.sv
`default_nettype none
// ============================================================================
// Module   : mem_array
// Brief    : 32-word storage, one sync write port, fill and peek async reads
// Revision : 1.0 - initial release
// ============================================================================
module mem_array
    import mem_pkg::*;
(
    input  wire logic              clock,
    input  wire logic              reset,
    input  wire logic              we,
    input  wire logic [ADDR_W-1:0] waddr,
    input  wire logic [DATA_W-1:0] wdata,
    input  wire logic [ADDR_W-1:0] fill_addr,
    output logic      [DATA_W-1:0] fill_data,
    input  wire logic [ADDR_W-1:0] peek_addr,
    output logic      [DATA_W-1:0] peek_data
);

    logic [DATA_W-1:0] r_mem [MEM_WORDS];

    // Reset restores the known pattern mem[i] = i[2:0], discarding all writes
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < MEM_WORDS; i++) begin
                r_mem[i] <= DATA_W'(i);
            end
        end else if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign fill_data = r_mem[fill_addr];
    assign peek_data = r_mem[peek_addr];

endmodule
`default_nettype wire

// File: rtl/main_memory_responder.sv
`default_nettype none
// ============================================================================
// Module   : main_memory_responder
// Brief    : Fixed-latency single-outstanding backing store below the L1 cache
// Revision : 1.0 - initial release
// ============================================================================
module main_memory_responder
    import mem_pkg::*;
#(
    parameter int LATENCY = 2
) (
    input  wire logic                clock,
    input  wire logic                reset,
    main_memory_responder_if.slave   bus
);

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic [1:0]        r_op;
    logic [ADDR_W-1:0] r_addr;
    logic              r_req_ready;
    logic              r_resp_valid;
    logic [DATA_W-1:0] r_resp_data;
    logic [DATA_W-1:0] r_peek_data;

    logic              w_accept;
    logic              w_is_wb;
    logic              w_is_write;
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_fill_data;
    logic [DATA_W-1:0] w_peek_data;

    localparam logic [3:0] c_CNT_SINGLE = 4'(LATENCY - 1);
    localparam logic [3:0] c_CNT_DOUBLE = 4'(2 * LATENCY - 1);

    assign w_accept   = (r_state == IDLE) && bus.req_valid;
    assign w_is_wb    = (bus.req_op == OP_WB_READ);
    assign w_is_write = (bus.req_op == OP_WRITE);

    // Both WRITE data and the WB_READ eviction commit on the acceptance edge,
    // so a fill of the evicted address later reads the freshly written word.
    assign w_we    = w_accept && (w_is_write || w_is_wb);
    assign w_waddr = w_is_wb ? bus.wb_address : bus.req_address;
    assign w_wdata = w_is_wb ? bus.wb_data    : bus.req_wdata;

    mem_array u_mem_array (
        .clock     (clock),
        .reset     (reset),
        .we        (w_we),
        .waddr     (w_waddr),
        .wdata     (w_wdata),
        .fill_addr (r_addr),
        .fill_data (w_fill_data),
        .peek_addr (bus.peek_address),
        .peek_data (w_peek_data)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_op         <= OP_READ;
            r_addr       <= '0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_peek_data  <= '0;
        end else begin
            r_peek_data <= w_peek_data;
            case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        // Reserved op 11 collapses onto READ here
                        r_op        <= w_is_wb ? OP_WB_READ : (w_is_write ? OP_WRITE : OP_READ);
                        r_addr      <= bus.req_address;
                        r_cnt       <= w_is_wb ? c_CNT_DOUBLE : c_CNT_SINGLE;
                        r_req_ready <= 1'b0;
                        r_state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_resp_valid <= 1'b1;
                        r_resp_data  <= (r_op == OP_WRITE) ? '0 : w_fill_data;
                        r_state      <= RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    r_resp_valid <= 1'b0;
                    r_req_ready  <= 1'b1;
                    r_state      <= IDLE;
                end
                default: begin
                    r_resp_valid <= 1'b0;
                    r_req_ready  <= 1'b1;
                    r_state      <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = r_req_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_data  = r_resp_data;
    assign bus.peek_data  = r_peek_data;

endmodule
`default_nettype wire

// File: tb/tb_main_memory_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_main_memory_responder
// Brief    : Directed scoreboard bench for main_memory_responder (LATENCY=2)
// Revision : 1.0 - initial release
// ============================================================================
module tb_main_memory_responder;

    localparam int LAT = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    main_memory_responder_if bus ();

    main_memory_responder #(.LATENCY(LAT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [2:0] data;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   last_acc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every response must match the oldest expectation, in data and cycle
    always @(negedge clock) begin
        if (!reset && bus.resp_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp actual=resp_valid expected=idle (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("resp_data", int'(bus.resp_data), int'(e.data));
                check("resp_cycle", cyc, e.cyc);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge with
    // req_valid still asserted so callers can chain or drop it.
    task automatic issue(input logic [1:0] op, input logic [4:0] a, input logic [2:0] wd,
                         input logic [4:0] wa, input logic [2:0] wbd,
                         input logic [2:0] exp, input bit push);
        int n;
        n = 0;
        bus.req_valid   = 1'b1;
        bus.req_op      = op;
        bus.req_address = a;
        bus.req_wdata   = wd;
        bus.wb_address  = wa;
        bus.wb_data     = wbd;
        while (!bus.req_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!bus.req_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=ready_low expected=ready_high");
        end
        last_acc = cyc + 1;
        if (push) q.push_back('{exp, cyc + 1 + LAT * ((op == 2'b10) ? 2 : 1)});
        @(negedge clock);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("drain_queue", q.size(), 0);
        @(negedge clock);
    endtask

    initial begin
        int n;
        int acc_a;
        bus.req_valid    = 1'b0;
        bus.req_op       = 2'b00;
        bus.req_address  = '0;
        bus.req_wdata    = '0;
        bus.wb_address   = '0;
        bus.wb_data      = '0;
        bus.peek_address = 5'd7;

        // Reset state
        repeat (2) @(negedge clock);
        check("rst_ready", int'(bus.req_ready), 1);
        check("rst_resp_valid", int'(bus.resp_valid), 0);
        check("rst_resp_data", int'(bus.resp_data), 0);
        check("rst_peek", int'(bus.peek_data), 0);
        reset = 1'b0;
        @(negedge clock);
        check("peek_init_7", int'(bus.peek_data), 7);

        // READ 16 -> init value 000, ready low for LAT+1 cycles
        issue(2'b00, 5'b10000, 3'b000, 5'd0, 3'b000, 3'b000, 1'b1);
        bus.req_valid = 1'b0;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            n++;
            @(negedge clock);
        end
        check("ready_low_cycles", n, LAT + 1);
        drain();

        // WRITE 1 <- 101, peek shows it one cycle later, READ back
        bus.peek_address = 5'b00001;
        issue(2'b01, 5'b00001, 3'b101, 5'd0, 3'b000, 3'b000, 1'b1);
        bus.req_valid = 1'b0;
        @(negedge clock);
        check("peek_after_write", int'(bus.peek_data), 5);
        drain();
        issue(2'b00, 5'b00001, 3'b000, 5'd0, 3'b000, 3'b101, 1'b1);
        bus.req_valid = 1'b0;
        drain();

        // WB_READ: evict 9 <- 100, fill 5 -> 101
        bus.peek_address = 5'b01001;
        issue(2'b10, 5'b00101, 3'b000, 5'b01001, 3'b100, 3'b101, 1'b1);
        bus.req_valid = 1'b0;
        @(negedge clock);
        check("peek_after_wb", int'(bus.peek_data), 4);
        drain();

        // WB_READ to the same address returns the evicted data
        issue(2'b10, 5'b01101, 3'b000, 5'b01101, 3'b001, 3'b001, 1'b1);
        bus.req_valid = 1'b0;
        drain();

        // Reserved op behaves as READ: addr 6 -> 110
        issue(2'b11, 5'b00110, 3'b000, 5'd0, 3'b000, 3'b110, 1'b1);
        bus.req_valid = 1'b0;
        drain();

        // Request held while busy: second accepted right after RESP
        issue(2'b00, 5'b00010, 3'b000, 5'd0, 3'b000, 3'b010, 1'b1);
        acc_a = last_acc;
        issue(2'b00, 5'b00111, 3'b000, 5'd0, 3'b000, 3'b111, 1'b1);
        bus.req_valid = 1'b0;
        check("held_accept_cycle", last_acc, acc_a + LAT + 2);
        drain();

        // Reset during WAIT drops the WRITE and reinitialises memory
        bus.peek_address = 5'b00011;
        issue(2'b01, 5'b00011, 3'b111, 5'd0, 3'b000, 3'b000, 1'b0);
        bus.req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("ready_after_reset", int'(bus.req_ready), 1);
        @(negedge clock);
        check("peek_after_reset", int'(bus.peek_data), 3);
        repeat (6) @(negedge clock);
        check("no_pending_after_reset", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/main_memory_responder.md
# main_memory_responder

Backing-store responder for the 2-way, 4-set L1 write-back cache: holds the 32-word × 3-bit main memory and services the cache's line-fill, write-through-on-eviction and combined write-back-then-fill requests over a single-outstanding valid/ready request channel with fixed, parameterised latency. It sits directly below the L1 and replaces the zero-latency memory model. A debug peek port lets benches print any memory word without disturbing traffic.

## Interface
- LATENCY, 2, cycles from request acceptance to response per memory access; legal range 1..8
- ADDR_W, 5, address width (32 words)
- DATA_W, 3, word width
- clock  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  cache presents a request
- req_ready  out  1  responder can accept; high only in IDLE
- req_op  in  2  00 READ, 01 WRITE, 10 WB_READ, 11 reserved (treated as READ)
- req_address  in  ADDR_W  read/fill address (also write address for WRITE)
- req_wdata  in  DATA_W  write data for WRITE
- wb_address  in  ADDR_W  eviction address for WB_READ
- wb_data  in  DATA_W  eviction data for WB_READ
- resp_valid  out  1  one-cycle response pulse
- resp_data  out  DATA_W  read data; valid with resp_valid for READ/WB_READ, 0 for WRITE
- peek_address  in  ADDR_W  debug address
- peek_data  out  DATA_W  mem[peek_address], registered (one-cycle delay)

## Operation
- States: IDLE (req_ready=1), WAIT (counting), RESP (resp_valid=1). IDLE→WAIT on req_valid&&req_ready; WAIT→RESP when cnt==0, else cnt−1; RESP→IDLE unconditionally.
- On acceptance: latch op/address; cnt ← LATENCY−1 for READ/WRITE, 2·LATENCY−1 for WB_READ.
- WRITE: mem[req_address] ← req_wdata at the acceptance edge.
- WB_READ: mem[wb_address] ← wb_data at the acceptance edge; fill read happens later, so wb_address==req_address returns wb_data.
- Read data sampled from the array at the WAIT→RESP edge into resp_data; held until next RESP; resp_data ← 0 for WRITE.
- req_valid while not IDLE is ignored; requester holds request until accepted.
- Reserved op 11 behaves exactly as READ.
- Peek port is read-only, independent of FSM; shows post-write value one cycle after a committing edge.

## Timing
- Reset (priority over everything): state IDLE, req_ready=1, resp_valid=0, resp_data=0, cnt=0, peek_data=0, mem[i] ← i[2:0] for all 32 words.
- Accept at edge E: resp_valid high from edge E+LATENCY to E+LATENCY+1 (READ/WRITE), from E+2·LATENCY to E+2·LATENCY+1 (WB_READ).
- req_ready low from E through the RESP cycle; next acceptance earliest at edge E+LATENCY+2 (READ/WRITE).
- LATENCY=1: WAIT lasts one cycle (cnt loads 0).
- Reset asserted mid-WAIT or in RESP: transaction dropped, no resp_valid, memory reinitialised (committed writes lost).
- Counter 4 bits; 2·8−1=15 fits.

## Structure
- Package mem_pkg: ADDR_W, DATA_W, MEM_WORDS=32, op encodings OP_READ/OP_WRITE/OP_WB_READ, state enum IDLE/WAIT/RESP.
- Sub-module mem_array: 32×DATA_W storage, one sync write port, two combinational read ports (fill, peek), synchronous reset init to i[2:0].
- Top: FSM, latency counter, request latches, response and peek registers.

## Test plan
- Reset, then READ addr 5'b10000 (LATENCY=2) -> resp_valid exactly 2 cycles after acceptance, resp_data=000; req_ready low 3 cycles.
- WRITE addr 5'b00001 data 101, then READ 5'b00001 -> WRITE resp_data=000, READ resp_data=101; peek 5'b00001 shows 101 one cycle after WRITE acceptance.
- WB_READ wb 5'b01001/100, read 5'b00101 -> resp after 4 cycles, resp_data=101 (init), peek 5'b01001=100.
- WB_READ with wb_address=req_address=5'b01101, wb_data 001 -> resp_data=001.
- req_valid held while busy with different address -> only first accepted; second accepted in cycle after RESP.
- Reset pulse during WAIT after WRITE 5'b00011/111 -> no resp_valid, req_ready=1 next cycle, peek 5'b00011=011.
